chan_scan_mux: RTL and testbench
================================

# chan_scan_mux

Registered, parametrised N-channel multiplexer with a manual-select mode and an auto-scan mode. In auto-scan an internal sequencer steps through the channels, dwelling a fixed number of cycles on each. It sits between a bank of parallel input words and a single downstream consumer, such as a display or serial packer, and replaces the fixed combinational 4:1 `mux` wherever channel count, data width or time-division scanning must vary.

## Interface
- `N_CH`, 4: number of input channels, 2..16, not required to be a power of 2.
- `W`, 1: data width per channel, in bits.
- `DWELL`, 4: cycles spent on each channel in auto-scan, 1..255.
- `SW`, derived: $clog2(N_CH); select width. Not overridable.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `mode`  in  1  0 = manual (channel from `s`); 1 = auto-scan.
- `en`  in  1  auto-scan advance enable. Ignored in manual mode.
- `s`  in  SW  manual channel select.
- `i`  in  N_CH*W  packed inputs; channel k occupies `i[k*W +: W]`.
- `y`  out  W  registered selected data.
- `ch`  out  SW  channel currently driving `y`.
- `valid`  out  1  `y`/`ch` hold a legitimately selected value.
- `wrap`  out  1  one-cycle pulse when auto-scan steps from channel N_CH-1 to 0.
- `err`  out  1  one-cycle pulse when manual `s` >= N_CH.

## Operation
- Reset (`rst`=1 at an edge): `y`=0, `ch`=0, `valid`=0, `wrap`=0, `err`=0. The internal channel counter and the dwell counter both go to 0. Reset overrides every other input.
- Every non-reset edge: `y` <= `i[sel*W +: W]`, `ch` <= sel, `valid` <= 1.
- Manual mode (`mode`=0): sel = `s`.
  - If `s` >= N_CH: `y` and `ch` hold their values, `valid` holds, and `err` pulses for one cycle.
  - The internal counter tracks `s` only when `s` is in range.
- Auto-scan mode (`mode`=1): sel = internal channel counter `cnt`.
  - With `en`=1, the dwell counter increments every cycle.
  - When the dwell counter reaches DWELL-1, it clears to 0 and `cnt` advances.
  - `cnt` advances to `cnt`+1, or to 0 from N_CH-1. The step to 0 raises `wrap` for that cycle.
  - With `en`=0, both counters freeze, but `y` keeps resampling `i` on the current channel.
- Mode 0→1 transition: `cnt` starts from the last in-range manual channel and the dwell counter is cleared. The first auto channel therefore gets a full DWELL cycles.
- Mode 1→0 transition: takes effect at the same edge; sel = `s` immediately, and the dwell counter is cleared.
- `wrap` and `err` are never both high; `err` is only possible in manual mode and `wrap` only in auto mode.
- With DWELL=1 and `en`=1, the channel advances every cycle, and `wrap` pulses once every N_CH cycles.

## Timing
- Latency is 1 cycle from `i`/`s` to `y`/`ch`. There is no combinational path from any input to any output.
- `valid` rises at the first edge after `rst` deasserts and stays high until the next reset.
- Auto-scan period is N_CH*DWELL cycles per full sweep while `en` stays high. `ch` changes exactly DWELL cycles apart.
- `wrap` is asserted in the same cycle that `ch` first shows 0 after N_CH-1.
- Reset mid-scan: at the reset edge, the counters and outputs return to their reset values. After release, scanning restarts from channel 0 with a full dwell.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with `i`=4'b1010 and `mode`=0 → `y`=0, `ch`=0, `valid`=0. One edge after release, with `s`=1: `y`=1, `ch`=1, `valid`=1.
- Manual sweep (N_CH=4, W=1): step `s` 0..3 with `i`=4'b0110 → `y` = 0,1,1,0, each one cycle after the `s` change. Also increment `s` and `i` together every 5 cycles and check `y` against a reference model.
- Out-of-range (N_CH=3, W=8): `s`=3 for one cycle after `s`=2 with `i[23:16]`=8'hA5 → `y` stays 8'hA5, `ch` stays 2, `err`=1 for exactly one cycle.
- Auto-scan (N_CH=4, DWELL=4, `en`=1) from reset → `ch` sequence is 0×4, 1×4, 2×4, 3×4, 0. `wrap`=1 only in cycle 16 after release.
- Enable gating: with `en`=0 for 6 cycles mid-dwell on channel 2, `ch` stays 2 and `y` follows changes on `i[2]`. After `en` returns to 1, the remaining dwell completes.
- Mode switch and mid-op reset: manual `s`=3, then `mode`=1 → channel 3 for 4 cycles, then 0 with `wrap`=1. Assert `rst` during channel 1 → next `ch` is 0, `valid` is 0, and a full dwell follows release.

Source files
------------

// File: rtl/chan_scan_mux.sv
// chan_scan_mux: registered N-channel mux with manual select and auto-scan sequencer.
module chan_scan_mux #(
  parameter int N_CH = 4,
  parameter int W = 1,
  parameter int DWELL = 4,
  localparam int SW = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mode,
  input  logic            en,
  input  logic [SW-1:0]   s,
  input  logic [N_CH*W-1:0] i,
  output logic [W-1:0]    y,
  output logic [SW-1:0]   ch,
  output logic            valid,
  output logic            wrap,
  output logic            err
);
  logic [SW-1:0] cnt_q, cnt_d, nxt, sel, ch_q;
  logic [7:0] dw_q, dw_d;
  logic [W-1:0] y_q;
  logic valid_q, wrap_q, err_q, in_rng, step, last;
  always_comb begin
    in_rng = 32'(s) < N_CH;
    last = cnt_q == SW'(N_CH - 1);
    step = mode && en && (dw_q == 8'(DWELL - 1));
    nxt = last ? '0 : cnt_q + 1'b1;
    cnt_d = mode ? (step ? nxt : cnt_q) : (in_rng ? s : cnt_q);
    dw_d = !mode ? '0 : !en ? dw_q : step ? '0 : dw_q + 8'd1;
    // in auto mode the output shows the channel the counter moves to at this edge
    sel = mode ? cnt_d : s;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      dw_q <= '0;
      y_q <= '0;
      ch_q <= '0;
      valid_q <= 1'b0;
      wrap_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      dw_q <= dw_d;
      wrap_q <= step && last;
      err_q <= !mode && !in_rng;
      if (mode || in_rng) begin
        y_q <= i[sel*W +: W];
        ch_q <= sel;
        valid_q <= 1'b1;
      end
    end
  end
  assign y = y_q;
  assign ch = ch_q;
  assign valid = valid_q;
  assign wrap = wrap_q;
  assign err = err_q;
endmodule

// File: tb/tb_chan_scan_mux.sv
// tb_chan_scan_mux: directed and random checks of two chan_scan_mux configurations against a scan model.
module tb_chan_scan_mux;
  logic clk = 1'b0, rst = 1'b1, mode = 1'b0, en = 1'b0;
  logic [1:0] s0 = '0, s1 = '0;
  logic [3:0] i0 = '0;
  logic [23:0] i1 = '0;
  logic [0:0] y0;
  logic [7:0] y1;
  logic [1:0] ch0, ch1;
  logic v0, w0, e0, v1, w1, e1;
  int vec = 0, miss = 0;
  int m_cnt[2], m_dw[2], m_y[2], m_ch[2], m_val[2], m_wrap[2], m_err[2];
  logic [1:0] pat [4];

  always #5 clk = ~clk;

  chan_scan_mux #(.N_CH(4), .W(1), .DWELL(4)) u0 (
    .clk(clk), .rst(rst), .mode(mode), .en(en), .s(s0), .i(i0),
    .y(y0), .ch(ch0), .valid(v0), .wrap(w0), .err(e0));
  chan_scan_mux #(.N_CH(3), .W(8), .DWELL(1)) u1 (
    .clk(clk), .rst(rst), .mode(mode), .en(en), .s(s1), .i(i1),
    .y(y1), .ch(ch1), .valid(v1), .wrap(w1), .err(e1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Channel-level behaviour: which channel is shown, when the scan moves on, and the pulses.
  task automatic model(input int k, input int s, input logic [31:0] din);
    int n = k ? 3 : 4;
    int d = k ? 1 : 4;
    int w = k ? 8 : 1;
    if (rst) begin
      m_cnt[k] = 0; m_dw[k] = 0; m_y[k] = 0; m_ch[k] = 0;
      m_val[k] = 0; m_wrap[k] = 0; m_err[k] = 0;
    end else if (!mode) begin
      m_wrap[k] = 0;
      m_dw[k] = 0;
      m_err[k] = int'(s >= n);
      if (s < n) begin
        m_y[k] = int'((din >> (s * w)) & ((32'd1 << w) - 1));
        m_ch[k] = s; m_val[k] = 1; m_cnt[k] = s;
      end
    end else begin
      m_err[k] = 0;
      m_wrap[k] = 0;
      if (en) begin
        m_dw[k]++;
        if (m_dw[k] == d) begin
          m_dw[k] = 0;
          m_wrap[k] = int'(m_cnt[k] == n - 1);
          m_cnt[k] = (m_cnt[k] + 1) % n;
        end
      end
      m_y[k] = int'((din >> (m_cnt[k] * w)) & ((32'd1 << w) - 1));
      m_ch[k] = m_cnt[k];
      m_val[k] = 1;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model(0, int'(s0), {28'b0, i0});
    model(1, int'(s1), {8'b0, i1});
    #1;
    chk("y0", y0, m_y[0]); chk("ch0", ch0, m_ch[0]); chk("valid0", v0, m_val[0]);
    chk("wrap0", w0, m_wrap[0]); chk("err0", e0, m_err[0]);
    chk("y1", y1, m_y[1]); chk("ch1", ch1, m_ch[1]); chk("valid1", v1, m_val[1]);
    chk("wrap1", w1, m_wrap[1]); chk("err1", e1, m_err[1]);
    chk("excl0", w0 & e0, 0); chk("excl1", w1 & e1, 0);
  endtask

  initial begin
    pat = '{2'd0, 2'd1, 2'd1, 2'd0};
    // reset held for three cycles
    i0 = 4'b1010;
    for (int n = 0; n < 3; n++) begin
      cyc();
      chk("rst_y", y0, 0); chk("rst_ch", ch0, 0); chk("rst_valid", v0, 0);
    end
    rst = 1'b0; s0 = 2'd1;
    cyc();
    chk("rel_y", y0, 1); chk("rel_ch", ch0, 1); chk("rel_valid", v0, 1);
    // manual sweep
    i0 = 4'b0110;
    for (int n = 0; n < 4; n++) begin
      s0 = 2'(n);
      cyc();
      chk("sweep_y", y0, pat[n]);
    end
    for (int n = 0; n < 20; n++) begin
      if (n % 5 == 0) begin s0 = s0 + 2'd1; i0 = i0 + 4'd1; end
      cyc();
    end
    // out-of-range select on the 3-channel instance
    s1 = 2'd2; i1 = {8'hA5, 8'h3C, 8'h0F};
    cyc();
    s1 = 2'd3; i1 = {8'h11, 8'h22, 8'h33};
    cyc();
    chk("oor_y", y1, 8'hA5); chk("oor_ch", ch1, 2); chk("oor_err", e1, 1);
    s1 = 2'd1;
    cyc();
    chk("oor_err_clr", e1, 0); chk("oor_back", y1, 8'h22);
    // auto-scan from reset
    rst = 1'b1;
    cyc();
    rst = 1'b0; mode = 1'b1; en = 1'b1;
    for (int n = 1; n <= 18; n++) begin
      i0 = 4'($urandom); i1 = 24'($urandom);
      cyc();
      chk("auto_ch", ch0, (n / 4) % 4); chk("auto_wrap", w0, n == 16);
    end
    // enable gating mid-dwell on channel 2
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int n = 0; n < 9; n++) cyc();
    en = 1'b0;
    for (int n = 0; n < 6; n++) begin
      i0 = 4'($urandom); i1 = 24'($urandom);
      cyc();
      chk("gate_ch", ch0, 2); chk("gate_y", y0, i0[2]);
    end
    en = 1'b1;
    for (int n = 0; n < 6; n++) cyc();
    // manual to auto switch, then reset mid-scan
    mode = 1'b0; s0 = 2'd3;
    cyc();
    mode = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      cyc();
      chk("sw_ch", ch0, n < 4 ? 3 : n < 8 ? 0 : 1); chk("sw_wrap", w0, n == 4);
    end
    rst = 1'b1;
    cyc();
    chk("mid_rst_ch", ch0, 0); chk("mid_rst_valid", v0, 0);
    rst = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      cyc();
      chk("post_rst_ch", ch0, n < 4 ? 0 : 1);
    end
    // random traffic
    for (int n = 0; n < 400; n++) begin
      rst = $urandom_range(0, 39) == 0;
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      en = $urandom_range(0, 3) != 0;
      s0 = 2'($urandom); s1 = 2'($urandom);
      i0 = 4'($urandom); i1 = 24'($urandom);
      cyc();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
